// File: rtl/instr_queue_exec.sv
// Instruction queue feeding a small multi-cycle ALU: {opcode,a,b} entries are pushed with
// save, popped one at a time while run is high, and each result is announced with valid_out.
module instr_queue_exec #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    input  logic [2:0]               opcode,
    input  logic                     save,
    input  logic                     run,
    output logic [2:0]               alu_sel,
    output logic [WIDTH-1:0]         alu_out,
    output logic                     carry_out,
    output logic [WIDTH-1:0]         data_out,
    output logic                     valid_out,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 3 + 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, EXEC, DIV, DONE} state_t;
    state_t state, state_next;

    logic [EW-1:0]      mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic               push, pop;
    logic [EW-1:0]      head;
    logic [2:0]         head_op;
    logic [WIDTH-1:0]   head_a, head_b;

    logic [2:0]         op_code;
    logic [WIDTH-1:0]   op_a, op_b;
    logic [WIDTH-1:0]   rem_q, quo_q, rem_d, quo_d;
    logic [WIDTH:0]     shifted, diff;
    logic [CW-1:0]      div_cnt;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign push    = save & ~full;
    assign pop     = (state == IDLE) & run & ~empty;
    assign head    = mem[rd_ptr];
    assign head_op = head[EW-1 -: 3];
    assign head_a  = head[2*WIDTH-1 -: WIDTH];
    assign head_b  = head[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {opcode, a, b};
    end

    // A push against a full queue is dropped even when a pop frees a slot in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (save && full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (pop) state_next = (head_op == 3'b110 && head_b != '0) ? DIV : EXEC;
            EXEC: state_next = DONE;
            DIV:  if (div_cnt == DIV_LAST) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Single-cycle ALU; opcode 110 only reaches EXEC when the divisor is zero.
    always_comb begin
        sum     = {1'b0, op_a} + {1'b0, op_b};
        prod    = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};
        alu_res = '0;
        alu_c   = 1'b0;
        case (op_code)
            3'b000: begin alu_res = sum[WIDTH-1:0]; alu_c = sum[WIDTH]; end
            3'b001: begin alu_res = op_a - op_b; alu_c = (op_a < op_b); end
            3'b010: alu_res = op_a & op_b;
            3'b011: alu_res = op_a | op_b;
            3'b100: alu_res = op_a ^ op_b;
            3'b101: begin alu_res = prod[WIDTH-1:0]; alu_c = |prod[2*WIDTH-1:WIDTH]; end
            3'b110: begin alu_res = '1; alu_c = 1'b1; end
            default: begin alu_res = {{(WIDTH-1){1'b0}}, op_a == op_b}; alu_c = (op_a > op_b); end
        endcase
    end

    // Restoring division step: shift the next dividend bit into the remainder, keep it if it fits.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, op_b};
        if (!diff[WIDTH]) begin
            rem_d = diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d = shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_code   <= '0;
            op_a      <= '0;
            op_b      <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            div_cnt   <= '0;
            alu_sel   <= '0;
            alu_out   <= '0;
            carry_out <= 1'b0;
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= (state == DONE);
            case (state)
                IDLE: if (pop) begin
                    op_code <= head_op;
                    op_a    <= head_a;
                    op_b    <= head_b;
                    alu_sel <= head_op;
                    rem_q   <= '0;
                    quo_q   <= head_a;
                    div_cnt <= '0;
                end
                EXEC: begin
                    alu_out   <= alu_res;
                    carry_out <= alu_c;
                    if (op_code != 3'b111) data_out <= alu_res;
                end
                DIV: begin
                    rem_q   <= rem_d;
                    quo_q   <= quo_d;
                    div_cnt <= div_cnt + 1'b1;
                    if (div_cnt == DIV_LAST) begin
                        alu_out   <= quo_d;
                        carry_out <= 1'b0;
                        data_out  <= quo_d;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/instr_queue_exec.md
INSTR_QUEUE_EXEC -- requirements
Module: instr_queue_exec

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (WIDTH >= 4).
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the instruction queue entries (power of 2, >= 2); AW = log2(DEPTH).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL change only on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, synchronous, active-high.
REQ-005 The block SHALL have port a, input, WIDTH bits, operand A.
REQ-006 The block SHALL have port b, input, WIDTH bits, operand B.
REQ-007 The block SHALL have port opcode, input, 3 bits, operation select.
REQ-008 The block SHALL have port save, input, 1 bit, push strobe for {opcode,a,b}.
REQ-009 The block SHALL have port run, input, 1 bit, execution enable.
REQ-010 The block SHALL have port alu_sel, output, 3 bits, opcode of the instruction in execution or last executed.
REQ-011 The block SHALL have port alu_out, output, WIDTH bits, result of the last completed instruction.
REQ-012 The block SHALL have port carry_out, output, 1 bit, flag of the last completed instruction.
REQ-013 The block SHALL have port data_out, output, WIDTH bits, stored result, updated only on completion of an instruction whose opcode is not 111.
REQ-014 The block SHALL have port valid_out, output, 1 bit, one-cycle completion pulse.
REQ-015 The block SHALL have port count, output, AW+1 bits, queue occupancy.
REQ-016 The block SHALL have ports full and empty, outputs, 1 bit each, decoded from count.
REQ-017 The block SHALL have port overflow, output, 1 bit, sticky dropped-push flag.

Function
REQ-018 Push: save=1 and full=0 SHALL write {opcode,a,b} at the tail; save=1 with full=1 SHALL drop the entry and set overflow, even if a pop occurs the same cycle.
REQ-019 Push and pop in the same cycle SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-020 FSM states SHALL be IDLE, EXEC, DIV, DONE.
REQ-021 IDLE with run=1 and empty=0 SHALL pop the head into operand registers and drive alu_sel; the next state SHALL be DIV if opcode=110 and b!=0, otherwise EXEC.
REQ-022 IDLE with run=0 or empty=1 SHALL stay in IDLE; run SHALL NOT affect an instruction already popped.
REQ-023 EXEC SHALL last one cycle, register the result, and go to DONE.
REQ-024 Opcode 000 SHALL compute alu_out = a+b mod 2^WIDTH, with carry_out = carry out of bit WIDTH-1.
REQ-025 Opcode 001 SHALL compute alu_out = a-b mod 2^WIDTH, with carry_out = 1 iff a<b (unsigned).
REQ-026 Opcodes 010, 011 and 100 SHALL compute AND, OR and XOR respectively, with carry_out = 0.
REQ-027 Opcode 101 SHALL compute alu_out = low WIDTH bits of a*b, with carry_out = 1 iff the high WIDTH bits are nonzero.
REQ-028 Opcode 110 with b=0 SHALL complete in EXEC with alu_out all ones and carry_out = 1.
REQ-029 Opcode 110 with b!=0 SHALL run an unsigned restoring division in DIV for exactly WIDTH cycles, then give alu_out = quotient, carry_out = 0, and go to DONE.
REQ-030 Opcode 111 SHALL compute alu_out = 1 if a==b else 0, with carry_out = 1 iff a>b (unsigned); data_out SHALL be unchanged.
REQ-031 DONE SHALL assert valid_out for exactly one cycle, with alu_out, carry_out and data_out already updated, and then go to IDLE.
REQ-032 Latency from the save edge to valid_out SHALL be 3 cycles for non-DIV operations and WIDTH+2 cycles for DIV, given run=1 and an empty idle queue.
REQ-033 alu_out, carry_out and data_out SHALL hold their values between completions.

Reset
REQ-034 reset=1 SHALL, on the next edge, set the FSM to IDLE and clear pointers and count, discarding queued and in-flight instructions.
REQ-035 reset=1 SHALL, on the same edge, set alu_out, data_out, alu_sel, carry_out, valid_out and overflow to 0, and set empty=1 and full=0.
REQ-036 reset SHALL take priority over save and run in the same cycle.

Verification
REQ-037 With WIDTH=8 and run=1, push a=5, b=3 for opcodes 000 to 111 in turn; the bench SHALL see alu_out = 8, 2, 1, 7, 6, 15, 1, 0 with carry_out = 0, 0, 0, 0, 0, 0, 0, 1, and data_out = 1 after the 111 op.
REQ-038 With run=1, push add a=8'hFF, b=8'h01 -> alu_out=0 and carry_out=1; push mul a=8'h10, b=8'h10 -> alu_out=0 and carry_out=1; push div b=0 -> alu_out=8'hFF and carry_out=1.
REQ-039 With run=1, push div a=200, b=7 -> valid_out SHALL rise exactly 10 cycles after the save edge, with alu_out = 28.
REQ-040 With run=0, push DEPTH+1 entries -> full=1, count=DEPTH, overflow=1; then set run=1 -> exactly DEPTH valid_out pulses in push order, and empty=1 at the end.
REQ-041 Assert reset during DIV with 3 entries queued -> on the next edge count=0, no valid_out pulse follows, and all outputs are 0.
